// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-requester round-robin arbiter.
// The index encoding matches the 8:3 encoder: bit D[i] maps to index i.
package arb_pkg;

   localparam int N     = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // OR-style encoder: for a one-hot input this returns the set bit's position.
   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] d);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (d[i]) begin
            idx = idx | IDX_W'(i);
         end
      end
      return idx;
   endfunction

   function automatic logic [N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      logic [N-1:0] d;
      d = '0;
      d[idx] = 1'b1;
      return d;
   endfunction

endpackage

// File: rtl/rr_pick_8x3.sv
// Combinational round-robin pick: first set bit of (req & mask) searching
// upward from ptr with wrap-around; idx is only meaningful when found=1.
module rr_pick_8x3
   import arb_pkg::*;
(
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   input  logic [N-1:0]     mask,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [N-1:0]     cand;
   logic [N-1:0]     rot;
   logic [IDX_W-1:0] src [N];
   logic [IDX_W-1:0] off;

   assign cand = req & mask;

   // rot[j] is the candidate sitting j places after ptr (index math wraps mod 8).
   for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign src[gi] = ptr + IDX_W'(gi);
      assign rot[gi] = cand[src[gi]];
   end

   always_comb begin
      off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = IDX_W'(i);
         end
      end
   end

   assign found = |cand;
   assign idx   = ptr + off;

endmodule

// File: rtl/rr_arbiter_8x3.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant, encoded
// index and a hold-time limit that forces rotation under contention.
module rr_arbiter_8x3
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             preempt
);

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [7:0]       hold_q, hold_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic             preempt_q, preempt_d;

   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic [N-1:0]     pick_mask;
   logic             owner_req;
   logic             others_req;

   // Excluding the owner is harmless outside expiry: on release its req is
   // already low, and in IDLE gnt_q is zero so nothing is masked.
   assign pick_mask  = ~gnt_q;
   assign owner_req  = |(req & gnt_q);
   assign others_req = |(req & ~gnt_q);

   rr_pick_8x3 u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .mask  (pick_mask),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hold_d      = hold_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      preempt_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d     = BUSY;
               gnt_d       = idx_to_onehot(pick_idx);
               gnt_valid_d = 1'b1;
               ptr_d       = pick_idx + 1'b1;
               hold_d      = '0;
            end
         end
         BUSY: begin
            if (!owner_req) begin
               hold_d = '0;
               if (pick_found) begin
                  gnt_d = idx_to_onehot(pick_idx);
                  ptr_d = pick_idx + 1'b1;
               end else begin
                  state_d     = IDLE;
                  gnt_d       = '0;
                  gnt_valid_d = 1'b0;
               end
            end else if (others_req) begin
               if (hold_q == HOLD_LAST) begin
                  gnt_d     = idx_to_onehot(pick_idx);
                  ptr_d     = pick_idx + 1'b1;
                  hold_d    = '0;
                  preempt_d = 1'b1;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end else begin
               hold_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      gnt_idx_d = onehot_to_idx(gnt_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         hold_q      <= '0;
         gnt_q       <= '0;
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
         preempt_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_q      <= hold_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         preempt_q   <= preempt_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = gnt_valid_q;
   assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_8x3.sv
// Directed bench for rr_arbiter_8x3 (MAX_HOLD=4) with hand-computed grants.
module tb_rr_arbiter_8x3;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       preempt;

   int n_checks;
   int n_pass;

   rr_arbiter_8x3 #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("ok   %-14s got=%0h", tag, got);
      end else begin
         $display("FAIL %-14s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                            input logic ev, input logic ep);
      check({tag, ".gnt"}, 32'(gnt), 32'(eg));
      check({tag, ".idx"}, 32'(gnt_idx), 32'(ei));
      check({tag, ".valid"}, 32'(gnt_valid), 32'(ev));
      check({tag, ".preempt"}, 32'(preempt), 32'(ep));
   endtask

   logic [7:0] hold_gnt [9];
   logic       hold_pre [9];
   int         bad_gnt;
   int         pulses;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst = 1'b1;
      req = 8'h00;
      repeat (3) tick();
      check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      check_out("idle", 8'h00, 3'd0, 1'b0, 1'b0);

      // single requester, then drop (ptr -> 6)
      req = 8'h20;
      tick();
      check_out("single", 8'h20, 3'd5, 1'b1, 1'b0);
      req = 8'h00;
      tick();
      check_out("single_drop", 8'h00, 3'd0, 1'b0, 1'b0);

      // handoff 3 -> 6 with no idle gap
      req = 8'h08;
      tick();
      check_out("own3", 8'h08, 3'd3, 1'b1, 1'b0);
      req = 8'h48;
      tick();
      check_out("own3_keep", 8'h08, 3'd3, 1'b1, 1'b0);
      req = 8'h40;
      tick();
      check_out("handoff", 8'h40, 3'd6, 1'b1, 1'b0);
      req = 8'h00;
      tick();
      check("handoff_end", 32'(gnt_valid), 32'd0);

      // async reset mid-grant
      req = 8'h04;
      tick();
      check_out("own2", 8'h04, 3'd2, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1;
      check_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
      req = 8'h81;
      tick();
      rst = 1'b0;
      tick();
      check_out("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);

      // fairness with req=FF, each owner releases after 2 cycles
      for (int k = 0; k < 8; k++) begin
         req = 8'hFF;
         tick();
         check("fair_hold", 32'(gnt), 32'(8'h01 << k));
         req = 8'hFF & ~(8'h01 << k);
         tick();
         check("fair_next", 32'(gnt_idx), 32'((k + 1) % 8));
      end
      check_out("fair_wrap", 8'h01, 3'd0, 1'b1, 1'b0);

      // hold limit: restart from ptr=0
      req = 8'h00;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      hold_gnt = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h01};
      hold_pre = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      req = 8'h03;
      for (int c = 0; c < 9; c++) begin
         tick();
         check($sformatf("hold%0d.gnt", c), 32'(gnt), 32'(hold_gnt[c]));
         check($sformatf("hold%0d.pre", c), 32'(preempt), 32'(hold_pre[c]));
      end
      req = 8'h00;
      tick();
      check("hold_end", 32'(gnt), 32'd0);

      // lone requester held for 100 cycles never gets preempted
      req = 8'h10;
      tick();
      check_out("solo", 8'h10, 3'd4, 1'b1, 1'b0);
      bad_gnt = 0;
      pulses  = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (gnt !== 8'h10) bad_gnt++;
         if (preempt !== 1'b0) pulses++;
      end
      check("solo_gnt_bad", 32'(bad_gnt), 32'd0);
      check("solo_pulses", 32'(pulses), 32'd0);
      req = 8'h00;
      tick();
      check_out("solo_end", 8'h00, 3'd0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_8x3.md
Name: rr_arbiter_8x3

Overview:
- Sequential round-robin arbiter that shares one downstream resource among 8 requesters.
- Produces a registered one-hot grant plus its 3-bit encoded index, using the same encoding as the team's 8:3 encoder (D[i] maps to index i).
- Holds a grant while the owner keeps its request high, subject to a hold-time limit that forces rotation when other requesters wait.
- Sits between the requester bank and the shared datapath mux/select logic.

Parameters:
- N, 8, number of requesters; fixed at 8 for this revision.
- IDX_W, 3, width of the encoded grant index; equals log2(N).
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant while others request; legal range 2..255.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; req[i]=1 means requester i wants the resource.
- gnt  output  8  registered one-hot grant; all zero when no owner.
- gnt_idx  output  3  registered encoded index of the owner; 3'b000 when gnt_valid=0.
- gnt_valid  output  1  high while any grant is asserted.
- preempt  output  1  one-cycle pulse, registered, in the cycle a grant is removed by hold-limit expiry.

Behaviour:
- Reset (asynchronous, active-high) drives the following and holds them while rst=1:
  - gnt=0, gnt_idx=0, gnt_valid=0, preempt=0.
  - state=IDLE, ptr=0, hold_cnt=0.
- ptr (3 bits) is the start point of the priority search.
  - Pick rule: the lowest index found in the wrapped order ptr, ptr+1, …, ptr+7 (mod 8) whose req bit is 1.
  - On every new grant to index k, ptr <= k+1 mod 8, wrapping 7 to 0.
- State IDLE (no owner):
  - If req has no bits set, stay in IDLE.
  - If req has any bit set, pick k. On the next edge: gnt=one-hot(k), gnt_idx=k, gnt_valid=1, hold_cnt=0, state -> BUSY.
  - Latency from req to gnt is one clock.
- State BUSY (owner o):
  - Release, req[o]=0:
    - If another req bit is set, pick a new owner; it is granted on the next edge with no idle gap.
    - Otherwise gnt clears on the next edge and state -> IDLE.
  - Hold, req[o]=1 and no other req bit set: grant stays, hold_cnt stays at 0.
  - Contention, req[o]=1 and another req bit set: hold_cnt increments.
    - When hold_cnt = MAX_HOLD-1, pick among the requesters excluding o.
    - The new owner is granted on the next edge, preempt=1 for that one cycle, and hold_cnt=0.
  - The owner's grant never changes while it holds its request below the limit, even if a higher-priority requester arrives.
- Simultaneous events:
  - Release and expiry in the same cycle: treated as a release; preempt=0.
  - A requester whose req drops in the same cycle it would be picked is not granted, because the pick uses the current req.
- gnt is always one-hot or zero. gnt_idx always equals the binary encoding of gnt.
- Reset asserted mid-grant: outputs clear immediately, without waiting for clk. After reset is released, arbitration restarts from ptr=0.
- No combinational path from req to any output.

Decomposition:
- Shared package arb_pkg holds:
  - constants N=8 and IDX_W=3;
  - a state enum {IDLE, BUSY};
  - a one-hot-to-index function matching the 8:3 encoder mapping.
- One combinational sub-module rr_pick_8x3 takes inputs req[7:0], ptr[2:0] and mask[7:0], where mask excludes the current owner on expiry. It outputs found and idx[2:0].
- The top level contains the FSM, ptr, hold_cnt and the output registers.

Test Plan:
- Reset check: assert rst mid-simulation with gnt=8'h04. Outputs clear asynchronously to all zero. After release with req=8'h81, gnt=8'h01 and gnt_idx=0 one cycle later.
- Single requester: req=8'h20 from IDLE gives gnt=8'h20, gnt_idx=5, gnt_valid=1 after one edge. Dropping req gives gnt=0 one cycle later.
- Fairness: hold req=8'hFF, with each owner releasing after 2 cycles by toggling only its own bit low for 1 cycle. Grant sequence is 0,1,2,…,7,0; ptr wraps 7 to 0.
- Hold limit with MAX_HOLD=4: req=8'h03 held continuously. Owner 0 holds for 4 cycles, then gnt=8'h02 with preempt=1 for exactly one cycle. Owner 1 then holds 4 cycles before returning to 0.
- No-preempt case: req=8'h10 held for 100 cycles with no other requests. Grant stays 8'h10 and preempt never pulses.
- Handoff without gap: owner 3 with req=8'h48; drop bit 3. Next edge gives gnt=8'h40 and gnt_idx=6, and gnt_valid never drops.
